// File: rtl/frq_sweep_sequencer.sv
// Frequency-sweep controller: steps a programmable table of divider select codes,
// changing F_select only on rising edges of the divided clock fed back on div_out.
module frq_sweep_sequencer #(
   parameter int STEPS   = 8,
   parameter int AW      = 3,
   parameter int SEL_W   = 5,
   parameter int DWELL_W = 8
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               cfg_we,
   input  logic [AW-1:0]      cfg_addr,
   input  logic [SEL_W-1:0]   cfg_sel,
   input  logic [DWELL_W-1:0] cfg_dwell,
   input  logic [AW-1:0]      last_step,
   input  logic               loop_en,
   input  logic               start,
   input  logic               stop,
   input  logic               div_out,
   output logic [SEL_W-1:0]   f_select,
   output logic [AW-1:0]      step_idx,
   output logic               busy,
   output logic               done
);

   typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

   localparam logic [AW-1:0]      ONE_A   = 1;
   localparam logic [DWELL_W:0]   ONE_CNT = 1;
   localparam logic [DWELL_W-1:0] ONE_DW  = 1;

   state_t              r_state;
   state_t              w_state_next;
   logic                r_div_q;
   logic                w_edge;
   logic [DWELL_W-1:0]  r_edge_cnt;
   logic [DWELL_W-1:0]  w_edge_cnt_next;
   logic [SEL_W-1:0]    r_f_select;
   logic [SEL_W-1:0]    w_f_select_next;
   logic [AW-1:0]       r_step_idx;
   logic [AW-1:0]       w_step_idx_next;
   logic                r_done;
   logic                w_done_next;
   logic [AW-1:0]       w_idx_inc;
   logic [DWELL_W-1:0]  w_dwell_eff;
   logic [DWELL_W:0]    w_cnt_inc;
   logic                w_step_end;

   logic [SEL_W-1:0]    r_tab_sel   [STEPS];
   logic [DWELL_W-1:0]  r_tab_dwell [STEPS];

   // Table lives in registers rather than block RAM because reset must clear it.
   genvar gi;
   generate
      for (gi = 0; gi < STEPS; gi++) begin : g_tab
         always_ff @(posedge clk) begin
            if (reset) begin
               r_tab_sel[gi]   <= '0;
               r_tab_dwell[gi] <= '0;
            end else if (cfg_we && (cfg_addr == AW'(gi))) begin
               r_tab_sel[gi]   <= cfg_sel;
               r_tab_dwell[gi] <= cfg_dwell;
            end
         end
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (reset) r_div_q <= 1'b0;
      else       r_div_q <= div_out;
   end

   assign w_edge      = div_out & ~r_div_q;
   assign w_idx_inc   = r_step_idx + ONE_A;
   // Dwell is read live so a rewrite of the running step's length takes effect at once.
   assign w_dwell_eff = (r_tab_dwell[r_step_idx] == '0) ? ONE_DW : r_tab_dwell[r_step_idx];
   assign w_cnt_inc   = {1'b0, r_edge_cnt} + ONE_CNT;
   assign w_step_end  = !(w_cnt_inc < {1'b0, w_dwell_eff});

   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (stop) begin
         w_state_next = IDLE;
      end else begin
         case (r_state)
            IDLE: if (start) w_state_next = RUN;
            RUN:  if (w_edge && w_step_end && (r_step_idx == last_step) && !loop_en)
                     w_state_next = IDLE;
            default: w_state_next = IDLE;
         endcase
      end
   end

   always_comb begin
      w_f_select_next = r_f_select;
      w_step_idx_next = r_step_idx;
      w_edge_cnt_next = r_edge_cnt;
      w_done_next     = 1'b0;
      if (!stop) begin
         if (r_state == IDLE) begin
            if (start) begin
               w_f_select_next = r_tab_sel[0];
               w_step_idx_next = '0;
               w_edge_cnt_next = '0;
            end
         end else if (w_edge) begin
            if (!w_step_end) begin
               w_edge_cnt_next = w_cnt_inc[DWELL_W-1:0];
            end else if (r_step_idx != last_step) begin
               w_step_idx_next = w_idx_inc;
               w_f_select_next = r_tab_sel[w_idx_inc];
               w_edge_cnt_next = '0;
            end else if (loop_en) begin
               w_step_idx_next = '0;
               w_f_select_next = r_tab_sel[0];
               w_edge_cnt_next = '0;
            end else begin
               w_done_next = 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_f_select <= '0;
         r_step_idx <= '0;
         r_edge_cnt <= '0;
         r_done     <= 1'b0;
      end else begin
         r_f_select <= w_f_select_next;
         r_step_idx <= w_step_idx_next;
         r_edge_cnt <= w_edge_cnt_next;
         r_done     <= w_done_next;
      end
   end

   always_comb begin
      busy = (r_state == RUN);
   end

   assign f_select = r_f_select;
   assign step_idx = r_step_idx;
   assign done     = r_done;

endmodule

// File: tb/tb_frq_sweep_sequencer.sv
// Directed bench for frq_sweep_sequencer: inputs change on the falling edge,
// outputs are checked on the falling edge after the acting rising edge.
module tb_frq_sweep_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_we;
   logic [2:0] cfg_addr;
   logic [4:0] cfg_sel;
   logic [7:0] cfg_dwell;
   logic [2:0] last_step;
   logic       loop_en;
   logic       start;
   logic       stop;
   logic       div_out;
   logic [4:0] f_select;
   logic [2:0] step_idx;
   logic       busy;
   logic       done;

   int total = 0;
   int bad   = 0;

   frq_sweep_sequencer dut (
      .clk       (clk),
      .reset     (reset),
      .cfg_we    (cfg_we),
      .cfg_addr  (cfg_addr),
      .cfg_sel   (cfg_sel),
      .cfg_dwell (cfg_dwell),
      .last_step (last_step),
      .loop_en   (loop_en),
      .start     (start),
      .stop      (stop),
      .div_out   (div_out),
      .f_select  (f_select),
      .step_idx  (step_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic cfg_write(input logic [2:0] a, input logic [4:0] s, input logic [7:0] d);
      @(negedge clk);
      cfg_we = 1'b1; cfg_addr = a; cfg_sel = s; cfg_dwell = d;
      @(negedge clk);
      cfg_we = 1'b0;
      $display("cfg write addr=%0d sel=%0d dwell=%0d", a, s, d);
   endtask

   task automatic div_rise();
      @(negedge clk);
      div_out = 1'b1;
      @(negedge clk);
      div_out = 1'b0;
   endtask

   task automatic do_start();
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic do_stop();
      @(negedge clk);
      stop = 1'b1;
      @(negedge clk);
      stop = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      total++; if (f_select !== 5'd0) begin bad++; $display("FAIL reset_fsel got=%0d exp=0", f_select); end
      total++; if (step_idx !== 3'd0) begin bad++; $display("FAIL reset_idx got=%0d exp=0", step_idx); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
      $display("reset: fsel=%0d idx=%0d busy=%b done=%b", f_select, step_idx, busy, done);
   endtask

   task automatic test_oneshot();
      cfg_write(3'd0, 5'd3, 8'd2);
      cfg_write(3'd1, 5'd7, 8'd1);
      last_step = 3'd1; loop_en = 1'b0;
      do_start();
      total++; if (f_select !== 5'd3 || busy !== 1'b1) begin bad++; $display("FAIL oneshot_start fsel=%0d busy=%b exp 3/1", f_select, busy); end
      div_rise();
      total++; if (f_select !== 5'd3) begin bad++; $display("FAIL oneshot_edge1 got=%0d exp=3", f_select); end
      div_rise();
      total++; if (f_select !== 5'd7 || step_idx !== 3'd1) begin bad++; $display("FAIL oneshot_edge2 fsel=%0d idx=%0d exp 7/1", f_select, step_idx); end
      div_rise();
      total++; if (busy !== 1'b0 || done !== 1'b1 || f_select !== 5'd7) begin bad++; $display("FAIL oneshot_end busy=%b done=%b fsel=%0d exp 0/1/7", busy, done, f_select); end
      @(negedge clk);
      total++; if (done !== 1'b0) begin bad++; $display("FAIL oneshot_done_pulse got=%b exp=0", done); end
      $display("oneshot: final fsel=%0d busy=%b", f_select, busy);
   endtask

   task automatic test_loop();
      logic [4:0] exp_sel [6] = '{5'd3, 5'd7, 5'd3, 5'd3, 5'd7, 5'd3};
      logic [2:0] exp_idx [6] = '{3'd0, 3'd1, 3'd0, 3'd0, 3'd1, 3'd0};
      loop_en = 1'b1;
      do_start();
      for (int k = 0; k < 6; k++) begin
         div_rise();
         total++;
         if (f_select !== exp_sel[k] || step_idx !== exp_idx[k] || done !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL loop_edge%0d fsel=%0d idx=%0d done=%b busy=%b exp %0d/%0d/0/1",
                     k, f_select, step_idx, done, busy, exp_sel[k], exp_idx[k]);
         end
         $display("loop edge %0d: fsel=%0d idx=%0d", k, f_select, step_idx);
      end
      do_stop();
      total++; if (busy !== 1'b0 || done !== 1'b0 || f_select !== 5'd3) begin bad++; $display("FAIL loop_stop busy=%b done=%b fsel=%0d exp 0/0/3", busy, done, f_select); end
   endtask

   task automatic test_dwell_bounds();
      int early = 0;
      cfg_write(3'd0, 5'd5, 8'd0);
      cfg_write(3'd1, 5'd6, 8'd255);
      last_step = 3'd1; loop_en = 1'b0;
      do_start();
      total++; if (f_select !== 5'd5) begin bad++; $display("FAIL dwell_start got=%0d exp=5", f_select); end
      div_rise();
      total++; if (f_select !== 5'd6 || step_idx !== 3'd1) begin bad++; $display("FAIL dwell0_step fsel=%0d idx=%0d exp 6/1", f_select, step_idx); end
      for (int k = 0; k < 254; k++) begin
         div_rise();
         if (busy !== 1'b1 || f_select !== 5'd6) early++;
      end
      total++; if (early != 0) begin bad++; $display("FAIL dwell255_early got=%0d early_exits exp=0", early); end
      div_rise();
      total++; if (busy !== 1'b0 || done !== 1'b1 || f_select !== 5'd6) begin bad++; $display("FAIL dwell255_end busy=%b done=%b fsel=%0d exp 0/1/6", busy, done, f_select); end
      $display("dwell: 255-edge step ended busy=%b done=%b", busy, done);
   endtask

   task automatic test_stop_edge();
      cfg_write(3'd0, 5'd3, 8'd2);
      cfg_write(3'd1, 5'd7, 8'd1);
      last_step = 3'd1; loop_en = 1'b1;
      @(negedge clk);
      start = 1'b1; stop = 1'b1;
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL stop_over_start busy=%b exp=0", busy); end
      do_start();
      div_rise();
      @(negedge clk);
      div_out = 1'b1; stop = 1'b1;
      @(negedge clk);
      div_out = 1'b0; stop = 1'b0;
      total++; if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL stop_edge_ctl busy=%b done=%b exp 0/0", busy, done); end
      total++; if (f_select !== 5'd3 || step_idx !== 3'd0) begin bad++; $display("FAIL stop_edge_hold fsel=%0d idx=%0d exp 3/0", f_select, step_idx); end
      $display("stop on edge: fsel=%0d idx=%0d busy=%b", f_select, step_idx, busy);
   endtask

   task automatic test_cfg_running();
      do_start();
      div_rise();
      cfg_write(3'd0, 5'd9, 8'd2);
      total++; if (f_select !== 5'd3) begin bad++; $display("FAIL cfgrun_hold got=%0d exp=3", f_select); end
      div_rise();
      total++; if (f_select !== 5'd7) begin bad++; $display("FAIL cfgrun_step1 got=%0d exp=7", f_select); end
      div_rise();
      total++; if (f_select !== 5'd9 || step_idx !== 3'd0) begin bad++; $display("FAIL cfgrun_refetch fsel=%0d idx=%0d exp 9/0", f_select, step_idx); end
      $display("cfg while running: refetched fsel=%0d", f_select);
   endtask

   task automatic test_reset_mid();
      div_rise();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      total++; if (f_select !== 5'd0 || step_idx !== 3'd0 || busy !== 1'b0 || done !== 1'b0) begin
         bad++; $display("FAIL midreset_outs fsel=%0d idx=%0d busy=%b done=%b exp all 0", f_select, step_idx, busy, done);
      end
      last_step = 3'd0; loop_en = 1'b0;
      do_start();
      total++; if (f_select !== 5'd0 || busy !== 1'b1) begin bad++; $display("FAIL midreset_table fsel=%0d busy=%b exp 0/1", f_select, busy); end
      div_rise();
      total++; if (busy !== 1'b0 || done !== 1'b1) begin bad++; $display("FAIL midreset_sweep busy=%b done=%b exp 0/1", busy, done); end
      $display("mid-sweep reset: restart fsel=%0d done=%b", f_select, done);
   endtask

   initial begin
      reset = 1'b1; cfg_we = 1'b0; cfg_addr = '0; cfg_sel = '0; cfg_dwell = '0;
      last_step = '0; loop_en = 1'b0; start = 1'b0; stop = 1'b0; div_out = 1'b0;
      test_reset();
      test_oneshot();
      test_loop();
      test_dwell_bounds();
      test_stop_edge();
      test_cfg_running();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
